// File: rtl/fifo_port_scheduler.sv
// Write-port sharer and read scheduler sitting in front of an 8-deep FIFO.
// Producers get round-robin grants with a burst cap; reads win except after two in a row.
module fifo_port_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int BURST_MAX  = 4,
    parameter int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  EN,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  grant0,
    output logic                  grant1,
    input  logic                  rdReq,
    output logic                  rdAck,
    output logic                  rdValid,
    output logic                  fifoEN,
    output logic                  fifoRst,
    output logic                  fifoWR,
    output logic                  fifoRD,
    output logic [DATA_WIDTH-1:0] fifoDataIn,
    output logic [LVL_W-1:0]      level
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [LVL_W-1:0] DEPTH_L    = LVL_W'(DEPTH);
    localparam logic [BW-1:0]    BURST_LAST = BW'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR0  = 2'd1,
        S_WR1  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [1:0]            streak_q, streak_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fifo_wr_q, fifo_rd_q, rd_valid_q, fifo_rst_q, fifo_en_q;

    logic                  active_s, own_req_s, rd_cand_s, wr_cand_s;
    logic                  rd_acc_s, wr_acc_s, burst_done_s;
    logic [DATA_WIDTH-1:0] wr_data_s;

    // Accept candidates and single-winner arbitration for this cycle
    always_comb begin
        active_s  = ~Rst & ~fifo_rst_q & EN;
        own_req_s = 1'b0;
        wr_data_s = data0;
        case (state_q)
            S_WR0: begin
                own_req_s = req0;
                wr_data_s = data0;
            end
            S_WR1: begin
                own_req_s = req1;
                wr_data_s = data1;
            end
            default: begin
                own_req_s = 1'b0;
                wr_data_s = data0;
            end
        endcase
        rd_cand_s    = rdReq & (level_q != {LVL_W{1'b0}});
        wr_cand_s    = own_req_s & (level_q != DEPTH_L);
        // two reads in a row hand the slot to a waiting writer
        rd_acc_s     = active_s & rd_cand_s & ~((streak_q == 2'd2) & wr_cand_s);
        wr_acc_s     = active_s & wr_cand_s & ~rd_acc_s;
        burst_done_s = wr_acc_s & (burst_q == BURST_LAST);
    end

    // Next-state for grant FSM, burst, streak, occupancy and write data
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        burst_d  = burst_q;
        streak_d = streak_q;
        level_d  = level_q;
        data_d   = data_q;
        if (EN) begin
            case (state_q)
                S_IDLE: begin
                    if (req0 & req1) begin
                        state_d = last_q ? S_WR0 : S_WR1;
                    end else if (req0) begin
                        state_d = S_WR0;
                    end else if (req1) begin
                        state_d = S_WR1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WR0: begin
                    if (~req0 | burst_done_s) begin
                        state_d = req1 ? S_WR1 : S_IDLE;
                        last_d  = 1'b0;
                        burst_d = {BW{1'b0}};
                    end else if (wr_acc_s) begin
                        burst_d = burst_q + BW'(1);
                    end else begin
                        burst_d = burst_q;
                    end
                end
                S_WR1: begin
                    if (~req1 | burst_done_s) begin
                        state_d = req0 ? S_WR0 : S_IDLE;
                        last_d  = 1'b1;
                        burst_d = {BW{1'b0}};
                    end else if (wr_acc_s) begin
                        burst_d = burst_q + BW'(1);
                    end else begin
                        burst_d = burst_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            if (rd_acc_s) begin
                streak_d = (streak_q == 2'd2) ? 2'd2 : streak_q + 2'd1;
            end else begin
                streak_d = 2'd0;
            end
        end else begin
            state_d  = state_q;
            streak_d = streak_q;
        end
        if (wr_acc_s) begin
            level_d = level_q + LVL_W'(1);
            data_d  = wr_data_s;
        end else if (rd_acc_s) begin
            level_d = level_q - LVL_W'(1);
        end else begin
            level_d = level_q;
        end
    end

    // State and FIFO-control registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b0;
            burst_q    <= {BW{1'b0}};
            streak_q   <= 2'd0;
            level_q    <= {LVL_W{1'b0}};
            data_q     <= {DATA_WIDTH{1'b0}};
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            fifo_rst_q <= 1'b1;
            fifo_en_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            streak_q   <= streak_d;
            level_q    <= level_d;
            data_q     <= data_d;
            fifo_wr_q  <= wr_acc_s;
            fifo_rd_q  <= rd_acc_s;
            rd_valid_q <= fifo_rd_q;
            fifo_rst_q <= 1'b0;
            fifo_en_q  <= EN;
        end
    end

    assign ack0       = wr_acc_s & (state_q == S_WR0);
    assign ack1       = wr_acc_s & (state_q == S_WR1);
    assign rdAck      = rd_acc_s;
    assign grant0     = (state_q == S_WR0);
    assign grant1     = (state_q == S_WR1);
    assign rdValid    = rd_valid_q;
    assign fifoEN     = fifo_en_q;
    assign fifoRst    = fifo_rst_q;
    assign fifoWR     = fifo_wr_q;
    assign fifoRD     = fifo_rd_q;
    assign fifoDataIn = data_q;
    assign level      = level_q;

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Directed bench for fifo_port_scheduler: reset, round-robin, stalls, starvation guard, EN freeze.
module tb_fifo_port_scheduler;

    logic        Clk;
    logic        Rst, EN, req0, req1, rdReq;
    logic [31:0] data0, data1;
    logic        ack0, ack1, grant0, grant1, rdAck, rdValid;
    logic        fifoEN, fifoRst, fifoWR, fifoRD;
    logic [31:0] fifoDataIn;
    logic [3:0]  level;

    int tests  = 0;
    int failed = 0;

    fifo_port_scheduler dut (
        .Clk(Clk), .Rst(Rst), .EN(EN),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .grant0(grant0), .grant1(grant1),
        .rdReq(rdReq), .rdAck(rdAck), .rdValid(rdValid),
        .fifoEN(fifoEN), .fifoRst(fifoRst), .fifoWR(fifoWR), .fifoRD(fifoRD),
        .fifoDataIn(fifoDataIn), .level(level)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] pat_rd;
        int         lv [6];
        pat_rd = 6'b011011;
        lv     = '{3, 2, 3, 2, 1, 2};

        Rst = 1'b1; EN = 1'b1; req0 = 1'b0; req1 = 1'b0; rdReq = 1'b0;
        data0 = 32'h0; data1 = 32'h0;
        tick(); tick();
        chk_w("rst_level", 32'(level), 32'd0);
        chk_b("rst_grant0", grant0, 1'b0);
        chk_b("rst_grant1", grant1, 1'b0);
        chk_b("rst_fifoWR", fifoWR, 1'b0);
        chk_b("rst_fifoRD", fifoRD, 1'b0);
        chk_b("rst_rdValid", rdValid, 1'b0);
        chk_w("rst_dataIn", fifoDataIn, 32'h0);
        chk_b("rst_fifoRst", fifoRst, 1'b1);
        chk_b("rst_fifoEN", fifoEN, 1'b1);
        Rst = 1'b0;
        tick();
        chk_b("rel_fifoRst", fifoRst, 1'b0);
        chk_b("rel_fifoEN", fifoEN, 1'b1);

        // Reset mid-burst
        req0 = 1'b1; data0 = 32'hA000_0000;
        settle();
        chk_b("A_idle_noack", ack0, 1'b0);
        tick();
        chk_b("A_grant0", grant0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            data0 = 32'hA000_0000 + 32'(i);
            settle();
            chk_b("A_ack0", ack0, 1'b1);
            tick();
            chk_w("A_level", 32'(level), 32'(i + 1));
            chk_w("A_data", fifoDataIn, 32'hA000_0000 + 32'(i));
        end
        Rst = 1'b1;
        settle();
        chk_b("A_rst_noack", ack0, 1'b0);
        tick();
        chk_w("A_rst_level", 32'(level), 32'd0);
        chk_b("A_rst_grant0", grant0, 1'b0);
        chk_b("A_rst_fifoWR", fifoWR, 1'b0);
        chk_b("A_rst_fifoRst", fifoRst, 1'b1);
        Rst = 1'b0; req0 = 1'b0;
        tick();
        chk_b("A_fifoRst_end", fifoRst, 1'b0);
        chk_b("A_post_fifoWR", fifoWR, 1'b0);
        chk_w("A_post_level", 32'(level), 32'd0);

        // Round-robin with burst cap; last=0 after reset so producer 1 goes first
        req0 = 1'b1; req1 = 1'b1; data0 = 32'h0000_00A0; data1 = 32'h0000_00B1;
        settle();
        chk_b("B_idle_ack0", ack0, 1'b0);
        chk_b("B_idle_ack1", ack1, 1'b0);
        tick();
        chk_b("B_grant1", grant1, 1'b1);
        chk_b("B_grant0", grant0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_b("B_ack1", ack1, 1'b1);
            chk_b("B_ack0_off", ack0, 1'b0);
            tick();
            chk_w("B_level1", 32'(level), 32'(i + 1));
            chk_w("B_data1", fifoDataIn, 32'h0000_00B1);
        end
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_b("B_ack0", ack0, 1'b1);
            chk_b("B_ack1_off", ack1, 1'b0);
            chk_b("B_grant0_sw", grant0, 1'b1);
            tick();
            chk_w("B_level0", 32'(level), 32'(i + 5));
            chk_w("B_data0", fifoDataIn, 32'h0000_00A0);
        end
        for (int i = 0; i < 2; i++) begin
            settle();
            chk_b("B_full_ack0", ack0, 1'b0);
            chk_b("B_full_ack1", ack1, 1'b0);
            tick();
            chk_w("B_full_level", 32'(level), 32'd8);
            chk_b("B_full_fifoWR", fifoWR, 1'b0);
            chk_b("B_full_grant1", grant1, 1'b1);
        end

        // Full stall released by one read
        req0 = 1'b0; rdReq = 1'b1;
        settle();
        chk_b("C_rdAck", rdAck, 1'b1);
        chk_b("C_ack1_stall", ack1, 1'b0);
        tick();
        chk_b("C_fifoRD", fifoRD, 1'b1);
        chk_b("C_fifoWR", fifoWR, 1'b0);
        chk_w("C_level7", 32'(level), 32'd7);
        rdReq = 1'b0;
        settle();
        chk_b("C_rdAck_off", rdAck, 1'b0);
        chk_b("C_ack1", ack1, 1'b1);
        tick();
        chk_b("C_fifoWR2", fifoWR, 1'b1);
        chk_b("C_rdValid", rdValid, 1'b1);
        chk_b("C_fifoRD_off", fifoRD, 1'b0);
        chk_w("C_level8", 32'(level), 32'd8);
        tick();
        chk_b("C_rdValid_end", rdValid, 1'b0);
        chk_b("C_fifoWR_off", fifoWR, 1'b0);

        // Drain to 4, then starvation guard pattern R R W R R W
        req1 = 1'b0; rdReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_b("D_drain_rdAck", rdAck, 1'b1);
            tick();
            chk_w("D_drain_level", 32'(level), 32'(7 - i));
        end
        rdReq = 1'b0;
        settle();
        chk_b("D_gap_rdAck", rdAck, 1'b0);
        tick();
        chk_w("D_gap_level", 32'(level), 32'd4);
        rdReq = 1'b1; req1 = 1'b1; data1 = 32'h0000_00D1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk_b("D_rdAck", rdAck, pat_rd[i]);
            chk_b("D_ack1", ack1, ~pat_rd[i]);
            tick();
            chk_w("D_level", 32'(level), 32'(lv[i]));
            chk_b("D_excl", fifoWR & fifoRD, 1'b0);
        end
        rdReq = 1'b0; req1 = 1'b0;
        tick();
        chk_w("D_end_level", 32'(level), 32'd2);

        // Empty read
        rdReq = 1'b1;
        settle();
        chk_b("E_rd1", rdAck, 1'b1);
        tick();
        settle();
        chk_b("E_rd2", rdAck, 1'b1);
        tick();
        chk_w("E_level0", 32'(level), 32'd0);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk_b("E_rdAck_empty", rdAck, 1'b0);
            tick();
            chk_b("E_fifoRD_empty", fifoRD, 1'b0);
            chk_w("E_level_empty", 32'(level), 32'd0);
        end
        rdReq = 1'b0;

        // EN freeze during producer 0 traffic
        req0 = 1'b1; data0 = 32'h0000_00C0;
        settle();
        chk_b("F_idle_ack0", ack0, 1'b0);
        tick();
        chk_b("F_grant0", grant0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk_b("F_ack0", ack0, 1'b1);
            tick();
            chk_w("F_level", 32'(level), 32'(i + 1));
            chk_b("F_fifoWR", fifoWR, 1'b1);
        end
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_b("F_frz_ack0", ack0, 1'b0);
            tick();
            chk_b("F_frz_fifoWR", fifoWR, 1'b0);
            chk_b("F_frz_fifoEN", fifoEN, 1'b0);
            chk_w("F_frz_level", 32'(level), 32'd2);
            chk_b("F_frz_grant0", grant0, 1'b1);
        end
        EN = 1'b1;
        settle();
        chk_b("F_resume_ack0", ack0, 1'b1);
        tick();
        chk_w("F_resume_level", 32'(level), 32'd3);
        chk_b("F_resume_fifoWR", fifoWR, 1'b1);
        chk_b("F_resume_fifoEN", fifoEN, 1'b1);
        settle();
        chk_b("F_last_ack0", ack0, 1'b1);
        tick();
        chk_w("F_last_level", 32'(level), 32'd4);
        chk_b("F_burst_release", grant0, 1'b0);
        req0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
